imem_loader: RTL

Runtime instruction-memory loader and core boot sequencer for the multicore NoC fabric. Consumes a byte stream (UART or debug bridge), parses per-node program packets, and drives the shared write port of the per-node instruction memories. It holds each core in reset while its program is written and releases it on completion or on a global release command.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_word_asm.sv | 43 ++++
 rtl/imem_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Node byte that releases every core instead of starting a program packet.
    localparam logic [7:0] CMD_RELEASE_ALL = 8'hFF;

    // Width of the packet word count and of the running word index.
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CNT_LO  = 3'd1,
        S_CNT_HI  = 3'd2,
        S_WORD    = 3'd3,
        S_DISCARD = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Assembles four little-endian stream bytes into one 32-bit instruction word.
// Latency: word valid combinationally with the 4th accepted byte.
// Backpressure: none; advances only on bytes the parent has already accepted.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_clr           drop any partial word and restart at byte 0
//   i_byte_vld/_dat accepted payload byte
//   o_word_vld      one-cycle pulse on the 4th byte of a word
//   o_word_dat      assembled word, valid with o_word_vld
module imem_word_asm (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat
);

    logic [1:0]  r_idx;
    logic [23:0] r_low;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_idx <= 2'd0;
            r_low <= 24'd0;
        end else if (i_byte_vld) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_low[7:0]   <= i_byte_dat;
                2'd1:    r_low[15:8]  <= i_byte_dat;
                2'd2:    r_low[23:16] <= i_byte_dat;
                default: ;  // top byte is taken straight from the input
            endcase
        end
    end

    // The top byte bypasses storage so the word is ready in the same cycle.
    assign o_word_vld = i_byte_vld && (r_idx == 2'd3);
    assign o_word_dat = {i_byte_dat, r_low};

endmodule

// File: rtl/imem_loader.sv
// Parses node/count/payload packets from a byte stream and writes per-node instruction memories.
// Latency: write strobe one cycle after the 4th byte of a word; done two cycles after the last byte.
// Backpressure: in_ready low only during the single FINISH cycle and while rst is high.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_in_data/_valid, o_in_ready  byte stream, accepted on valid && ready
//   o_wr_en/_node/_addr/_data     shared instruction-memory write port (registered)
//   o_core_rst                    per-core reset hold, all ones out of reset
//   o_busy, o_done, o_err         packet in progress, end-of-packet pulse, sticky error
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int NODES  = 16,
    parameter int SIZE   = 128,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [7:0]        o_wr_node,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic [NODES-1:0]  o_core_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_node;
    logic                r_node_ok;     // header named a real core
    logic                r_rel;         // header was the release-all command
    logic [COUNT_W-1:0]  r_count;
    logic [COUNT_W-1:0]  r_widx;

    logic                r_wr_en;
    logic [7:0]          r_wr_node;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic [NODES-1:0]    r_core_rst;
    logic                r_done;
    logic                r_err;

    logic                w_acc;
    logic                w_pay_acc;
    logic                w_word_vld;
    logic [31:0]         w_word_dat;
    logic                w_last_word;
    logic                w_in_range;
    logic                w_cnt_zero;
    logic                w_hdr_valid;
    logic [NODES-1:0]    w_hdr_mask;
    logic [NODES-1:0]    w_node_mask;

    assign w_pay_acc   = w_acc && ((r_state == S_WORD) || (r_state == S_DISCARD));
    assign w_last_word = ((r_widx + COUNT_W'(1)) == r_count);
    assign w_in_range  = (r_widx < COUNT_W'(SIZE));
    // Count is complete only once the high byte arrives, so test it off the input.
    assign w_cnt_zero  = ({i_in_data, r_count[7:0]} == '0);
    assign w_hdr_valid = (32'(i_in_data) < NODES);
    assign w_hdr_mask  = NODES'(1) << i_in_data;
    assign w_node_mask = NODES'(1) << r_node;

    imem_word_asm u_word_asm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (r_state == S_IDLE),
        .i_byte_vld (w_pay_acc),
        .i_byte_dat (i_in_data),
        .o_word_vld (w_word_vld),
        .o_word_dat (w_word_dat)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = !i_rst && (r_state != S_FINISH);
        w_acc       = i_in_valid && o_in_ready;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = (i_in_data == CMD_RELEASE_ALL) ? S_FINISH : S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (w_acc) begin
                    w_state_nxt = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (w_acc) begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_FINISH;
                    end else if (r_node_ok) begin
                        w_state_nxt = S_WORD;
                    end else begin
                        w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_WORD, S_DISCARD: begin
                if (w_word_vld && w_last_word) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_node     <= 8'd0;
            r_node_ok  <= 1'b0;
            r_rel      <= 1'b0;
            r_count    <= '0;
            r_widx     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_node  <= 8'd0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
            r_core_rst <= '1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_count <= '0;
                        r_widx  <= '0;
                        r_node  <= i_in_data;
                        if (i_in_data == CMD_RELEASE_ALL) begin
                            r_rel     <= 1'b1;
                            r_node_ok <= 1'b0;
                        end else if (w_hdr_valid) begin
                            r_rel      <= 1'b0;
                            r_node_ok  <= 1'b1;
                            r_core_rst <= r_core_rst | w_hdr_mask;
                        end else begin
                            r_rel     <= 1'b0;
                            r_node_ok <= 1'b0;
                            r_err     <= 1'b1;
                        end
                    end
                end
                S_CNT_LO: begin
                    if (w_acc) begin
                        r_count[7:0] <= i_in_data;
                    end
                end
                S_CNT_HI: begin
                    if (w_acc) begin
                        r_count[15:8] <= i_in_data;
                    end
                end
                S_WORD: begin
                    if (w_word_vld) begin
                        r_widx <= r_widx + COUNT_W'(1);
                        // Words past the memory depth are consumed but never written.
                        if (w_in_range) begin
                            r_wr_en   <= 1'b1;
                            r_wr_node <= r_node;
                            r_wr_addr <= r_widx[ADDR_W-1:0];
                            r_wr_data <= w_word_dat;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_word_vld) begin
                        r_widx <= r_widx + COUNT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    if (r_rel) begin
                        r_core_rst <= '0;
                    end else if (r_node_ok) begin
                        r_core_rst <= r_core_rst & ~w_node_mask;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_wr_en    = r_wr_en;
    assign o_wr_node  = r_wr_node;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_core_rst = r_core_rst;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule
